// File: rtl/i2c_pkg.sv
// i2c_pkg: shared sequencer state encoding, default widths and packed command word layout.
package i2c_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int CMD_W = 1 + DEF_ADDR_W + DEF_DATA_W;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_ADDR_LSB = DEF_DATA_W;
  localparam int CMD_RW_BIT = DEF_ADDR_W + DEF_DATA_W;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous DEPTH x W command FIFO with registered full/empty flags.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign cnt_n = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C commands and runs them one at a time on the master.
// Define I2C_SEQ_TIMEOUT_EN to add a watchdog that aborts hung commands with rsp_err.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_rw,
  output logic              m_enable,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rw,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);
  localparam int CW = 1 + ADDR_W + DATA_W;
  state_t state, state_n;
  logic full, empty, pop, tmo, fin, active;
  logic [CW-1:0] head;
  i2c_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk(clk), .rst(rst), .push(cmd_valid && cmd_ready), .din({cmd_rw, cmd_addr, cmd_data}),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  assign cmd_ready = !full;
  assign active = state == LAUNCH || state == BUSY;
  assign pop = state == IDLE && !empty && m_ready;
  assign fin = active && (tmo || (state == BUSY && m_ready));
  assign m_enable = state == LAUNCH;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wd;
  always_ff @(posedge clk) begin
    if (rst || pop) wd <= '0;
    else if (active) wd <= wd + 1'b1;
  end
  assign tmo = active && wd == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pop ? LAUNCH : IDLE;
      LAUNCH:  state_n = tmo ? RESP : (m_ready ? LAUNCH : BUSY);
      BUSY:    state_n = fin ? RESP : BUSY;
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      {m_rw, m_addr, m_data_in} <= '0;
      rsp_valid <= 1'b0;
      rsp_rw <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (pop) {m_rw, m_addr, m_data_in} <= head;
      if (fin) begin
        rsp_valid <= 1'b1;
        rsp_rw <= m_rw;
        rsp_data <= (m_rw && !tmo) ? m_data_out : '0;
        rsp_err <= tmo;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: randomized scoreboard bench with a behavioural I2C master model.
module tb_i2c_cmd_sequencer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_rw = 0;
  logic [6:0] cmd_addr = 0, m_addr;
  logic [7:0] cmd_data = 0, m_data_in, m_data_out, rsp_data;
  logic m_rw, m_enable, m_ready, rsp_valid, rsp_ready = 1, rsp_rw, rsp_err;
  int tests = 0, fails = 0;
  int n_launch = 0, n_rsp = 0, busy_len = 4, mph = 0, mcnt = 0, wdc = 0;
  bit hold = 0, hang = 0, use_a5 = 0, rr_rand = 0, held = 0, acc;
  logic [15:0] cmd_q[$];
  logic [16:0] exp_q[$];
  logic [15:0] l_cmd, lq;
  logic [16:0] hv, e;

  i2c_cmd_sequencer #(.DEPTH(4), .ADDR_W(7), .DATA_W(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .m_addr(m_addr), .m_data_in(m_data_in),
    .m_rw(m_rw), .m_enable(m_enable), .m_ready(m_ready), .m_data_out(m_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw), .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic fail_now(input string n);
    tests++;
    fails++;
    $display("FAIL %s", n);
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
    cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    ok = cmd_ready;
    if (ok) cmd_q.push_back({rw, a, d});
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (cmd_q.size() == 0 && exp_q.size() == 0 && n_launch == n_rsp && mph == 0 && !rsp_valid) break;
      cyc(1);
    end
    if (i == budget) fail_now("drain_timeout");
  endtask

  // Master model: accepts a launch after 0-2 cycles, stays busy busy_len cycles, then returns data.
  initial begin
    m_ready = 1; m_data_out = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        mph = 0; m_ready = 1;
      end else case (mph)
        0: if (m_enable) begin
          chk("one_outstanding", n_launch - n_rsp, 0);
          if (cmd_q.size() == 0) fail_now("launch_unexpected");
          else begin
            lq = cmd_q.pop_front();
            chk("launch_cmd", {m_rw, m_addr, m_data_in}, lq);
          end
          n_launch++;
          l_cmd = {m_rw, m_addr, m_data_in};
          if (hang) exp_q.push_back({m_rw, 8'h00, 1'b1});
          mcnt = $urandom_range(0, 2); wdc = 0; mph = 1;
        end else m_ready = !hold;
        1: begin
          wdc++;
          chk("enable_until_accept", m_enable, 1);
          if (mcnt == 0) begin m_ready = 0; mcnt = busy_len; mph = 2; end
          else mcnt--;
        end
        default: begin
          wdc++;
          chk("enable_low_busy", m_enable, 0);
          chk("m_stable", {m_rw, m_addr, m_data_in}, l_cmd);
          if (hang) begin
            if (rsp_valid) begin chk("timeout_cycles", wdc, 64); m_ready = 1; mph = 0; end
          end else if (mcnt == 0) begin
            m_data_out = use_a5 ? 8'hA5 : 8'($urandom);
            m_ready = 1;
            exp_q.push_back({l_cmd[15], l_cmd[15] ? m_data_out : 8'h00, 1'b0});
            mph = 0;
          end else mcnt--;
        end
      endcase
    end
  end

  // Response monitor: pops the scoreboard on every handshake and checks hold stability.
  initial forever begin
    @(negedge clk);
    if (held && rsp_valid) chk("rsp_stable", {rsp_rw, rsp_data, rsp_err}, hv);
    held = rsp_valid && !rsp_ready;
    hv = {rsp_rw, rsp_data, rsp_err};
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) fail_now("rsp_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("rsp", {rsp_rw, rsp_data, rsp_err}, e);
      end
      n_rsp++;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int base, en_cnt;
    cyc(2);
    rst = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_m_enable", m_enable, 0);
    chk("rst_m_word", {m_rw, m_addr, m_data_in}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_word", {rsp_rw, rsp_data, rsp_err}, 0);

    busy_len = 30;
    send(0, 7'b0101011, 8'hEE, acc);
    chk("write_accepted", acc, 1);
    chk("latency_cycle1", m_enable, 0);
    cyc(1);
    chk("latency_cycle2", m_enable, 1);
    drain(300);
    chk("write_rsp_count", n_rsp, 1);

    use_a5 = 1; busy_len = 10;
    send(1, 7'h2B, 8'h00, acc);
    drain(300);
    use_a5 = 0;
    chk("read_rsp_count", n_rsp, 2);

    hold = 1; busy_len = 3;
    cyc(1);
    base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      send(1'($urandom), 7'($urandom), 8'($urandom), acc);
      chk("fill_accept", acc, i < 4);
    end
    chk("full_cmd_ready", cmd_ready, 0);
    hold = 0;
    drain(400);
    chk("fill_rsp_count", n_rsp - base, 4);

    rsp_ready = 0; base = n_rsp;
    send(1, 7'h11, 8'h22, acc);
    send(0, 7'h33, 8'h44, acc);
    cyc(50);
    chk("bp_single_launch", n_launch - base, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    rsp_ready = 1;
    drain(300);
    chk("bp_rsp_count", n_rsp - base, 2);

    busy_len = 50;
    for (int i = 0; i < 4; i++) send(0, 7'(i + 1), 8'(i), acc);
    cyc(5);
    rst = 1;
    cyc(1);
    rst = 0;
    cmd_q.delete(); exp_q.delete(); n_launch = 0; n_rsp = 0;
    chk("midrst_m_enable", m_enable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_m_addr", m_addr, 0);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); en_cnt += int'(m_enable); end
    chk("midrst_no_launch", en_cnt, 0);
    busy_len = 5;
    send(1, 7'h55, 8'h00, acc);
    drain(300);
    chk("post_rst_rsp_count", n_rsp, 1);

    rr_rand = 1; base = n_rsp;
    for (int i = 0; i < 30; i++) begin
      busy_len = $urandom_range(1, 8);
      acc = 0;
      for (int t = 0; t < 200 && !acc; t++) send(1'($urandom), 7'($urandom), 8'($urandom), acc);
      if (!acc) fail_now("random_push_stuck");
      cyc($urandom_range(0, 3));
    end
    drain(3000);
    rr_rand = 0; rsp_ready = 1;
    chk("random_rsp_count", n_rsp - base, 30);

`ifdef I2C_SEQ_TIMEOUT_EN
    hang = 1; base = n_rsp;
    send(1, 7'h7F, 8'h00, acc);
    drain(300);
    hang = 0;
    send(0, 7'h01, 8'h5A, acc);
    drain(300);
    chk("timeout_rsp_count", n_rsp - base, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
